// File: rtl/mul_result_buffer.sv
// mul_result_buffer: captures the product on each rising edge of mul_done and queues it in a valid/ready FIFO
module mul_result_buffer #(
    parameter int PW    = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mul_done,
    input  logic [PW-1:0] mul_prod,
    input  logic          flush,
    input  logic          clr_ovf,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [PW-1:0] out_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic [CW-1:0] cap_cnt
);
    logic [PW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_count;
    logic          r_done_q;
    logic          r_ovf;
    logic [CW-1:0] r_cap_cnt;
    logic          w_cap;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    assign w_cap     = mul_done & ~r_done_q;
    assign w_pop     = out_valid & out_ready;
    assign w_push    = w_cap & (~full | w_pop);
    // a capture lost to flush is discarded silently, not counted as overflow
    assign w_drop    = w_cap & full & ~w_pop & ~flush;
    assign count     = r_count;
    assign full      = r_count == (AW+1)'(DEPTH);
    assign empty     = r_count == '0;
    assign out_valid = ~empty;
    assign out_data  = r_mem[r_rd];
    assign ovf       = r_ovf;
    assign cap_cnt   = r_cap_cnt;

    always_ff @(posedge clk)
        if (w_push && !flush) r_mem[r_wr] <= mul_prod;

    // done_q resets high so a done already asserted at reset release is not captured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd      <= '0;
            r_wr      <= '0;
            r_count   <= '0;
            r_done_q  <= 1'b1;
            r_ovf     <= 1'b0;
            r_cap_cnt <= '0;
        end else begin
            r_done_q  <= mul_done;
            r_ovf     <= w_drop | (r_ovf & ~clr_ovf);
            if (w_cap) r_cap_cnt <= r_cap_cnt + CW'(1);
            if (flush) begin
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wr <= r_wr + AW'(1);
                if (w_pop) r_rd <= r_rd + AW'(1);
                if (w_push != w_pop) r_count <= w_push ? r_count + (AW+1)'(1) : r_count - (AW+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_mul_result_buffer.sv
// tb_mul_result_buffer: table vectors, directed corner cases and random stimulus against a queue model
module tb_mul_result_buffer;
    localparam int PW = 16, DEPTH = 4, AW = 2, CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mul_done = 1'b1;
    logic [PW-1:0] mul_prod = '0;
    logic          flush = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [PW-1:0] out_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          ovf;
    logic [CW-1:0] cap_cnt;

    int n_err = 0;
    int n_chk = 0;

    logic [PW-1:0] q[$];
    logic          m_ovf;
    logic [CW-1:0] m_cap;
    logic          m_prev;

    typedef struct {
        logic          d;
        logic [PW-1:0] p;
        logic          f;
        logic          c;
        logic          r;
        int            cnt;
        logic          v;
        logic [PW-1:0] dat;
        logic          ovf;
        int            cap;
    } vec_t;
    vec_t tbl[17];

    mul_result_buffer #(.PW(PW), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .mul_done(mul_done), .mul_prod(mul_prod),
        .flush(flush), .clr_ovf(clr_ovf), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .count(count), .full(full),
        .empty(empty), .ovf(ovf), .cap_cnt(cap_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, " valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({tag, " count"}, 32'(count), 32'(q.size()));
        chk({tag, " full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, " empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, " ovf"}, 32'(ovf), 32'(m_ovf));
        chk({tag, " cap_cnt"}, 32'(cap_cnt), 32'(m_cap));
        if (q.size() != 0) chk({tag, " data"}, 32'(out_data), 32'(q[0]));
    endtask

    // inputs applied just after a posedge, outputs sampled 1ns after the next one
    task automatic step(input logic d, input logic [PW-1:0] p, input logic f, input logic c, input logic r);
        logic cap, pop, was_full, set;
        mul_done = d; mul_prod = p; flush = f; clr_ovf = c; out_ready = r;
        @(posedge clk);
        #1;
        cap = d & ~m_prev;
        m_prev = d;
        pop = (q.size() != 0) & r;
        was_full = q.size() == DEPTH;
        set = 1'b0;
        if (cap) m_cap++;
        if (f) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (cap) begin
                if (!was_full || pop) q.push_back(p);
                else set = 1'b1;
            end
        end
        m_ovf = set | (m_ovf & ~c);
        cmp_model("model");
    endtask

    task automatic do_reset(input logic d);
        mul_done = d; flush = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete(); m_ovf = 1'b0; m_cap = '0; m_prev = 1'b1;
    endtask

    task automatic capture(input logic [PW-1:0] p, input logic r);
        step(1'b1, p, 1'b0, 1'b0, r);
        step(1'b0, '0, 1'b0, 1'b0, r);
    endtask

    initial begin
        logic [PW-1:0] exp4[4];
        logic [CW-1:0] cc;
        tbl = '{
            '{0, 16'h0015, 0, 0, 0, 0, 0, 16'h0000, 0, 0},
            '{1, 16'h0015, 0, 0, 0, 1, 1, 16'h0015, 0, 1},
            '{0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 0, 1},
            '{1, 16'h0001, 0, 0, 0, 1, 1, 16'h0001, 0, 2},
            '{0, 16'h0000, 0, 0, 0, 1, 1, 16'h0001, 0, 2},
            '{1, 16'h0002, 0, 0, 0, 2, 1, 16'h0001, 0, 3},
            '{0, 16'h0000, 0, 0, 0, 2, 1, 16'h0001, 0, 3},
            '{1, 16'h0003, 0, 0, 0, 3, 1, 16'h0001, 0, 4},
            '{0, 16'h0000, 0, 0, 0, 3, 1, 16'h0001, 0, 4},
            '{1, 16'h0004, 0, 0, 0, 4, 1, 16'h0001, 0, 5},
            '{0, 16'h0000, 0, 0, 0, 4, 1, 16'h0001, 0, 5},
            '{1, 16'h0005, 0, 0, 0, 4, 1, 16'h0001, 1, 6},
            '{0, 16'h0000, 0, 0, 1, 3, 1, 16'h0002, 1, 6},
            '{0, 16'h0000, 0, 0, 1, 2, 1, 16'h0003, 1, 6},
            '{0, 16'h0000, 0, 0, 1, 1, 1, 16'h0004, 1, 6},
            '{0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 1, 6},
            '{0, 16'h0000, 0, 1, 0, 0, 0, 16'h0000, 0, 6}
        };

        // done held high through reset release must not capture
        do_reset(1'b1);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 16'hbeef, 1'b0, 1'b0, 1'b0);
        chk("held done count", 32'(count), 32'd0);
        chk("held done cap_cnt", 32'(cap_cnt), 32'd0);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].d, tbl[i].p, tbl[i].f, tbl[i].c, tbl[i].r);
            chk($sformatf("tbl%0d count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d valid", i), 32'(out_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d full", i), 32'(full), 32'(tbl[i].cnt == DEPTH));
            chk($sformatf("tbl%0d ovf", i), 32'(ovf), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d cap_cnt", i), 32'(cap_cnt), 32'(tbl[i].cap));
            if (tbl[i].v) chk($sformatf("tbl%0d data", i), 32'(out_data), 32'(tbl[i].dat));
        end

        // full FIFO: capture and pop together keeps count at DEPTH without overflow
        capture(16'h0010, 1'b0);
        capture(16'h0020, 1'b0);
        capture(16'h0030, 1'b0);
        capture(16'h0040, 1'b0);
        chk("t4 full", 32'(full), 32'd1);
        step(1'b1, 16'h0050, 1'b0, 1'b0, 1'b1);
        chk("t4 count", 32'(count), 32'd4);
        chk("t4 ovf", 32'(ovf), 32'd0);
        exp4 = '{16'h0020, 16'h0030, 16'h0040, 16'h0050};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4 drain%0d", i), 32'(out_data), 32'(exp4[i]));
            step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        end
        chk("t4 empty", 32'(empty), 32'd1);

        // flush with a coincident capture discards it but still counts it
        capture(16'h0060, 1'b0);
        capture(16'h0070, 1'b0);
        cc = cap_cnt;
        step(1'b1, 16'h0080, 1'b1, 1'b0, 1'b0);
        chk("t5 count", 32'(count), 32'd0);
        chk("t5 empty", 32'(empty), 32'd1);
        chk("t5 ovf", 32'(ovf), 32'd0);
        chk("t5 cap_cnt", 32'(cap_cnt), 32'(cc + CW'(1)));
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // async reset mid-cycle with data queued and ovf set
        for (int i = 1; i <= 5; i++) capture(PW'(i), 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("t6 pre count", 32'(count), 32'd3);
        chk("t6 pre ovf", 32'(ovf), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 count", 32'(count), 32'd0);
        chk("t6 empty", 32'(empty), 32'd1);
        chk("t6 full", 32'(full), 32'd0);
        chk("t6 valid", 32'(out_valid), 32'd0);
        chk("t6 ovf", 32'(ovf), 32'd0);
        chk("t6 cap_cnt", 32'(cap_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete(); m_ovf = 1'b0; m_cap = '0; m_prev = 1'b1;

        do_reset(1'b0);
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 1)), PW'($urandom),
                 $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                 1'($urandom_range(0, 2) == 0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
